data_mem_bridge: RTL and testbench

Adapter between the harvard CPU's data port and a variable-latency data memory. The CPU expects combinational reads and single-cycle writes; this bridge stalls it via its clock-enable input while a real memory transaction (waitrequest / readdatavalid handshake) completes, then presents the captured read data stably for the enabled cycle. It sits directly downstream of the CPU data port and upstream of the data RAM / interconnect.

---
 rtl/data_mem_bridge.sv | 163 ++++++++++++++++
 tb/tb_data_mem_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// Stalls the CPU data port through its clock enable while a waitrequest/readdatavalid memory transaction completes.
// Optional repeated-read buffer: define DATA_MEM_BRIDGE_READ_BUF_EN.
//
// state   | meaning
// IDLE    | no transaction; CPU runs on sys_clk_enable
// RD_REQ  | mem_read held until accepted
// RD_WAIT | read accepted, waiting for readdatavalid
// WR_REQ  | mem_write held until accepted
// DONE    | result ready; one enabled CPU cycle then back to IDLE
module data_mem_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sys_clk_enable,
    output logic              cpu_clk_enable,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;

`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              tag_vld_q, tag_vld_d;
    logic              buf_hit;

    assign buf_hit = tag_vld_q && (cpu_address == tag_q);
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rbuf_d         = rbuf_q;
        cpu_clk_enable = 1'b0;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
        tag_d          = tag_q;
        tag_vld_d      = tag_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                cpu_clk_enable = sys_clk_enable;
                if (cpu_write) begin
                    cpu_clk_enable = 1'b0;
                    addr_d         = cpu_address;
                    wdata_d        = cpu_writedata;
                    state_d        = S_WR_REQ;
                    // a read colliding with the write is dropped and returns zero
                    if (cpu_read) begin
                        rbuf_d = 32'h0;
                    end
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
                    tag_vld_d = 1'b0;
`endif
                end else if (cpu_read) begin
                    cpu_clk_enable = 1'b0;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
                    if (buf_hit) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = cpu_address;
                        state_d = S_RD_REQ;
                    end
`else
                    addr_d  = cpu_address;
                    state_d = S_RD_REQ;
`endif
                end
            end
            S_RD_REQ: begin
                if (!mem_waitrequest) begin
                    if (mem_readdatavalid) begin
                        rbuf_d  = mem_readdata;
                        state_d = S_DONE;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
                        tag_d     = addr_q;
                        tag_vld_d = 1'b1;
`endif
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (mem_readdatavalid) begin
                    rbuf_d  = mem_readdata;
                    state_d = S_DONE;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
                    tag_d     = addr_q;
                    tag_vld_d = 1'b1;
`endif
                end
            end
            S_WR_REQ: begin
                if (!mem_waitrequest) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_clk_enable = sys_clk_enable;
                if (sys_clk_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // the CPU must be able to run its own reset while the bridge is held
        if (!reset) begin
            cpu_clk_enable = sys_clk_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rbuf_q    <= 32'h0;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
`endif
        end
    end

    assign mem_read      = (state_q == S_RD_REQ);
    assign mem_write     = (state_q == S_WR_REQ);
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign cpu_readdata  = rbuf_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: vector table, hand-written corner sequences, then random
// transactions against a transaction-level model and a behavioural memory.
module tb_data_mem_bridge;

`ifdef DATA_MEM_BRIDGE_READ_BUF_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sys_clk_enable;
    logic        cpu_clk_enable;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    always #5 clk = ~clk;

    data_mem_bridge #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .sys_clk_enable    (sys_clk_enable),
        .cpu_clk_enable    (cpu_clk_enable),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_writedata     (cpu_writedata),
        .cpu_readdata      (cpu_readdata),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // memory device seen by the DUT, and the model's view of what memory should hold
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          wait_left = 0;
    int          resp_l = 0;
    int          lat_cnt = 0;
    logic [31:0] pend = 32'h0;
    int          mem_txn = 0;

    // transaction-level model state
    logic [31:0] exp_buf = 32'h0;
    logic [31:0] tag = 32'h0;
    logic        tag_valid = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;
        int          l;
        int          stall;
        logic [31:0] data;
        logic        mem_tx;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // behavioural memory: waits wait_left cycles, then accepts; read data after resp_l cycles
    task automatic responder();
        mem_readdatavalid = 1'b0;
        mem_readdata      = $urandom;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = pend;
            end
        end
        if (mem_read || mem_write) begin
            if (wait_left > 0) begin
                mem_waitrequest = 1'b1;
                wait_left--;
            end else begin
                mem_waitrequest = 1'b0;
                mem_txn++;
                if (mem_read) begin
                    pend = dev_rd(mem_address);
                    if (resp_l == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata      = pend;
                    end else begin
                        lat_cnt = resp_l;
                    end
                end else begin
                    dev_mem[mem_address] = mem_writedata;
                end
            end
        end else begin
            mem_waitrequest = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_step(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int w, input int l,
                              output int stall, output logic [31:0] data, output logic mem_tx);
        if (wr) begin
            stall = 2 + w;
            ref_mem[addr] = wdata;
            tag_valid = 1'b0;
            if (rd) exp_buf = 32'h0;
            mem_tx = 1'b1;
        end else if (HIT_EN && tag_valid && addr == tag) begin
            stall  = 1;
            mem_tx = 1'b0;
        end else begin
            stall     = 2 + w + l;
            exp_buf   = ref_rd(addr);
            tag       = addr;
            tag_valid = 1'b1;
            mem_tx    = 1'b1;
        end
        data = exp_buf;
    endtask

    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int w, input int l, input int exp_stall,
                           input logic [31:0] exp_data, input logic exp_mem);
        int   stall = 0;
        int   strobes = 0;
        int   txn0 = mem_txn;
        logic got = 1'b0;
        logic stable_ok = 1'b1;
        wait_left = w;
        resp_l    = l;
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
        sys_clk_enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            responder();
            #1;
            if (mem_read || mem_write) begin
                strobes++;
                if (mem_address !== addr || (wr && mem_writedata !== wdata)) stable_ok = 1'b0;
            end
            if (cpu_clk_enable) begin
                got = 1'b1;
                break;
            end
            stall++;
            @(negedge clk);
        end
        chk({name, "_enable_seen"}, 32'(got), 32'd1);
        if (!got) return;
        chk({name, "_stall"}, stall, exp_stall);
        chk({name, "_rdata"}, cpu_readdata, exp_data);
        chk({name, "_strobes"}, strobes, exp_mem ? w + 1 : 0);
        chk({name, "_stable"}, 32'(stable_ok), 32'd1);
        chk({name, "_memtxn"}, mem_txn - txn0, exp_mem ? 1 : 0);
    endtask

    task automatic idle_cycle(input logic sys);
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = $urandom; sys_clk_enable = sys;
        responder();
        #1;
        chk("idle_enable", 32'(cpu_clk_enable), 32'(sys));
        chk("idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("idle_rdata", cpu_readdata, exp_buf);
    endtask

    task automatic set_vec(input int i, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int w, input int l, input int st,
                           input logic [31:0] d, input logic mt);
        tbl[i].rd = rd; tbl[i].wr = wr; tbl[i].addr = a; tbl[i].wdata = wd;
        tbl[i].w = w; tbl[i].l = l; tbl[i].stall = st; tbl[i].data = d; tbl[i].mem_tx = mt;
    endtask

    initial begin
        int          st;
        logic [31:0] dd;
        logic        mt;

        set_vec(0,  0, 1, 32'h10,   32'h12345678, 2, 0, 4, 32'h0, 1);
        set_vec(1,  1, 0, 32'h1000, 32'h0, 3, 1, 6, 32'hDEADBEEF, 1);
        set_vec(2,  1, 0, 32'h10,   32'h0, 0, 1, 3, 32'h12345678, 1);
        set_vec(3,  1, 0, 32'h10,   32'h0, 0, 1, HIT_EN ? 1 : 3, 32'h12345678, !HIT_EN);
        set_vec(4,  0, 1, 32'h20,   32'hCAFEF00D, 0, 0, 2, 32'h12345678, 1);
        set_vec(5,  1, 0, 32'h10,   32'h0, 1, 2, 5, 32'h12345678, 1);
        set_vec(6,  1, 1, 32'h30,   32'h55AA55AA, 0, 0, 2, 32'h0, 1);
        set_vec(7,  1, 0, 32'h30,   32'h0, 0, 3, 5, 32'h55AA55AA, 1);
        set_vec(8,  1, 0, 32'h2000, 32'h0, 0, 0, 2, 32'h0BADF00D, 1);
        set_vec(9,  1, 0, 32'h2000, 32'h0, 0, 1, HIT_EN ? 1 : 3, 32'h0BADF00D, !HIT_EN);
        set_vec(10, 0, 1, 32'h40,   32'h11111111, 0, 0, 2, 32'h0BADF00D, 1);
        set_vec(11, 1, 0, 32'h2000, 32'h0, 0, 1, 3, 32'h0BADF00D, 1);
        set_vec(12, 1, 0, 32'h20,   32'h0, 2, 0, 4, 32'hCAFEF00D, 1);

        dev_mem[32'h1000] = 32'hDEADBEEF; ref_mem[32'h1000] = 32'hDEADBEEF;
        dev_mem[32'h2000] = 32'h0BADF00D; ref_mem[32'h2000] = 32'h0BADF00D;

        reset = 1'b0; sys_clk_enable = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0;
        cpu_address = 32'h0; cpu_writedata = 32'h0;
        mem_waitrequest = 1'b0; mem_readdata = 32'h0; mem_readdatavalid = 1'b0;
        @(negedge clk); #1;
        chk("rst_enable_c1", 32'(cpu_clk_enable), 32'd1);
        @(negedge clk); #1;
        chk("rst_enable_c2", 32'(cpu_clk_enable), 32'd1);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_rdata", cpu_readdata, 32'h0);
        chk("rst_maddr", mem_address, 32'h0);
        chk("rst_mwdata", mem_writedata, 32'h0);
        @(negedge clk);
        reset = 1'b1; cpu_read = 1'b0;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        for (int i = 0; i < 13; i++) begin
            model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].w, tbl[i].l, st, dd, mt);
            run_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                    tbl[i].w, tbl[i].l, tbl[i].stall, tbl[i].data, tbl[i].mem_tx);
        end
        idle_cycle(1'b1);

        // DONE held for 5 cycles with sys_clk_enable low
        wait_left = 0; resp_l = 1;
        @(negedge clk);
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h1000; sys_clk_enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            responder(); #1;
            chk($sformatf("hold_stall%0d", c), 32'(cpu_clk_enable), 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            sys_clk_enable = 1'b0;
            responder(); #1;
            chk($sformatf("hold_en%0d", c), 32'(cpu_clk_enable), 32'd0);
            chk($sformatf("hold_rdata%0d", c), cpu_readdata, 32'hDEADBEEF);
            chk($sformatf("hold_strobe%0d", c), {30'h0, mem_read, mem_write}, 32'h0);
        end
        @(negedge clk);
        sys_clk_enable = 1'b1;
        responder(); #1;
        chk("hold_release_en", 32'(cpu_clk_enable), 32'd1);
        chk("hold_release_rdata", cpu_readdata, 32'hDEADBEEF);
        exp_buf = 32'hDEADBEEF; tag = 32'h1000; tag_valid = 1'b1;
        idle_cycle(1'b1);

        // reset during RD_WAIT, then a late readdatavalid
        wait_left = 0; resp_l = 100;
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 32'h3000; sys_clk_enable = 1'b1;
        responder(); #1;
        chk("rstmid_req_en", 32'(cpu_clk_enable), 32'd0);
        @(negedge clk);
        responder(); #1;
        chk("rstmid_rdreq", 32'(mem_read), 32'd1);
        @(negedge clk);
        responder(); #1;
        chk("rstmid_rdwait_en", 32'(cpu_clk_enable), 32'd0);
        chk("rstmid_rdwait_strobe", 32'(mem_read), 32'd0);
        reset = 1'b0; cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b1; lat_cnt = 0;
        mem_readdatavalid = 1'b1; mem_readdata = 32'hAAAAAAAA; mem_waitrequest = 1'b0;
        #1;
        chk("rstmid_rdata", cpu_readdata, 32'h0);
        chk("rstmid_en", 32'(cpu_clk_enable), 32'd1);
        chk("rstmid_strobe", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rstmid_maddr", mem_address, 32'h0);
        exp_buf = 32'h0; tag_valid = 1'b0;
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        for (int i = 0; i < 80; i++) begin
            int          k;
            logic        rd, wr;
            logic [31:0] a, wd;
            int          w, l;
            k  = $urandom_range(0, 9);
            rd = (k <= 5) || (k == 9);
            wr = (k >= 6);
            a  = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            wd = $urandom;
            w  = $urandom_range(0, 3);
            l  = $urandom_range(0, 3);
            model_step(rd, wr, a, wd, w, l, st, dd, mt);
            run_txn($sformatf("rnd%0d", i), rd, wr, a, wd, w, l, st, dd, mt);
            if ($urandom_range(0, 9) < 3) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
